// File: rtl/rv32i_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: merges load-use, redirect,
// dmem wait and external stall/flush requests into per-stage hold/squash strobes.
module rv32i_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             bubble_ex_o,
    output logic             bubble_wb_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_ex_mem_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    localparam int         REM_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic [REM_W-1:0] rem, rem_nxt;
    logic [CNT_W-1:0] stall_cnt, redir_cnt;
    logic             redir_acc;

    logic mem_wait;
    logic timeout;
    logic redirect;
    logic load_use;

    assign mem_wait = dmem_req_i & ~dmem_ack_i;
    // wait_cnt holds the number of unacked cycles already stalled; one more aborts.
    assign timeout  = mem_wait & (wait_cnt >= TIMEOUT_V);
    assign redirect = ex_valid_i & ex_redirect_i;
    assign load_use = ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                      ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                       (id_rs2_used_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        rem_nxt        = rem;
        redir_acc      = 1'b0;
        stall_if_o     = 1'b0;
        stall_id_o     = 1'b0;
        stall_ex_o     = 1'b0;
        stall_mem_o    = 1'b0;
        bubble_ex_o    = 1'b0;
        bubble_wb_o    = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_mem_o = 1'b0;
        mem_err_o      = 1'b0;

        if (!rst_ni) begin
            // Keep every pipeline register squashed while reset is held.
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
        end else if (flush_i) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            state_nxt      = ST_RUN;
            wait_cnt_nxt   = 8'd0;
            rem_nxt        = '0;
        end else if (timeout) begin
            mem_err_o      = 1'b1;
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            state_nxt      = ST_RUN;
            wait_cnt_nxt   = 8'd0;
            rem_nxt        = '0;
        end else if (mem_wait) begin
            stall_if_o     = 1'b1;
            stall_id_o     = 1'b1;
            stall_ex_o     = 1'b1;
            stall_mem_o    = 1'b1;
            bubble_wb_o    = 1'b1;
            state_nxt      = ST_MEM_WAIT;
            wait_cnt_nxt   = wait_cnt + 8'd1;
            rem_nxt        = '0;
        end else begin
            wait_cnt_nxt = 8'd0;
            if (stall_i) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
                bubble_wb_o = 1'b1;
            end else if (redirect) begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                redir_acc     = 1'b1;
                rem_nxt       = REM_W'(FLUSH_CYCLES - 1);
                state_nxt     = (FLUSH_CYCLES > 1) ? ST_REDIRECT : ST_RUN;
            end else if (state == ST_REDIRECT) begin
                // Extra IF/ID squash cycles cover the fetch already in flight.
                flush_if_id_o = 1'b1;
                rem_nxt       = rem - REM_W'(1);
                state_nxt     = (rem == REM_W'(1)) ? ST_RUN : ST_REDIRECT;
            end else begin
                state_nxt = ST_RUN;
                if (load_use) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            rem       <= '0;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rem      <= rem_nxt;
            if (stall_if_o) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redir_acc) begin
                redir_cnt <= redir_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;
    assign redir_cnt_o = redir_cnt;

endmodule
